// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the memory port arbiter.
// Port identifiers, the response latency constant and the alignment check.
package mem_arb_pkg;

  typedef enum logic {PORT_FETCH = 1'b0, PORT_DATA = 1'b1} port_id_t;

  localparam int RESP_LAT = 1;

  // Word accesses only; any nonzero low byte-offset is misaligned.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data and RAM-side signals around the memory port arbiter.
// The slave modport is the arbiter's view; master is the core+RAM view.
interface mem_port_arbiter_if
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16
);
  // Handshake: a transfer happens in a cycle where req and gnt are both high.
  // The requester holds req/addr/we/wdata stable until gnt; dropping req earlier
  // abandons the request. gnt is combinational; each granted transfer gets
  // exactly one rvalid pulse the following cycle, with err qualifying rvalid.
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [31:0]       if_rdata;
  logic              if_err;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [31:0]       d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_d;
  logic [31:0]       mem_q;

  port_id_t          dbg_last_gnt;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    output if_gnt, if_rvalid, if_rdata, if_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output mem_we, mem_addr, mem_d, dbg_last_gnt
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_q,
    input  if_gnt, if_rvalid, if_rdata, if_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  mem_we, mem_addr, mem_d, dbg_last_gnt
  );
endinterface

// File: rtl/mem_arb_pick.sv
// Combinational grant decision between fetch and data requests.
// MEM_ARB_RR_EN selects round-robin; otherwise data priority with a starvation override.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic     reset,
  input  logic     if_req,
  input  logic     d_req,
`ifdef MEM_ARB_RR_EN
  input  port_id_t last_gnt,
`else
  input  logic     starve_full,
`endif
  output logic     if_gnt,
  output logic     d_gnt
);

  logic fetch_wins;

`ifdef MEM_ARB_RR_EN
  assign fetch_wins = (last_gnt == PORT_DATA);
`else
  assign fetch_wins = starve_full;
`endif

  always_comb begin
    if_gnt = 1'b0;
    d_gnt  = 1'b0;
    if (!reset) begin
      if (if_req && d_req) begin
        if_gnt = fetch_wins;
        d_gnt  = !fetch_wins;
      end else begin
        if_gnt = if_req;
        d_gnt  = d_req;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port RAM arbiter between instruction fetch and load/store, registered responses.
// Build option MEM_ARB_RR_EN: round-robin arbitration instead of data priority + starvation guard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = 4
)(
  input  logic               clock,
  input  logic               reset,
  mem_port_arbiter_if.slave  bus
);

  port_id_t last_gnt;
  logic     if_gnt;
  logic     d_gnt;
  logic     if_mis;
  logic     d_mis;

  logic        if_rvalid_q, if_err_q;
  logic        d_rvalid_q, d_err_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  assign if_mis = is_misaligned(bus.if_addr[1:0]);
  assign d_mis  = is_misaligned(bus.d_addr[1:0]);

`ifdef MEM_ARB_RR_EN
  mem_arb_pick u_pick (
    .reset    (reset),
    .if_req   (bus.if_req),
    .d_req    (bus.d_req),
    .last_gnt (last_gnt),
    .if_gnt   (if_gnt),
    .d_gnt    (d_gnt)
  );
`else
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Counts consecutive cycles fetch waited; saturates so fetch keeps priority until served.
  always_ff @(posedge clock) begin
    if (reset || !bus.if_req || if_gnt) starve_cnt <= '0;
    else if (starve_cnt != CNT_MAX)     starve_cnt <= starve_cnt + 1'b1;
  end

  mem_arb_pick u_pick (
    .reset       (reset),
    .if_req      (bus.if_req),
    .d_req       (bus.d_req),
    .starve_full (starve_cnt == CNT_MAX),
    .if_gnt      (if_gnt),
    .d_gnt       (d_gnt)
  );
`endif

  always_ff @(posedge clock) begin
    if (reset)       last_gnt <= PORT_FETCH;
    else if (d_gnt)  last_gnt <= PORT_DATA;
    else if (if_gnt) last_gnt <= PORT_FETCH;
  end

  assign bus.if_gnt       = if_gnt;
  assign bus.d_gnt        = d_gnt;
  assign bus.dbg_last_gnt = last_gnt;

  always_comb begin
    bus.mem_addr = '0;
    bus.mem_d    = '0;
    bus.mem_we   = 1'b0;
    if (d_gnt) begin
      bus.mem_addr = bus.d_addr;
      bus.mem_d    = bus.d_wdata;
      bus.mem_we   = bus.d_we && !d_mis;
    end else if (if_gnt) begin
      bus.mem_addr = bus.if_addr;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      if_rvalid_q <= 1'b0;
      if_err_q    <= 1'b0;
      if_rdata_q  <= '0;
      d_rvalid_q  <= 1'b0;
      d_err_q     <= 1'b0;
      d_rdata_q   <= '0;
    end else begin
      if_rvalid_q <= if_gnt;
      if_err_q    <= if_gnt && if_mis;
      if_rdata_q  <= (if_gnt && !if_mis) ? bus.mem_q : 32'h0;
      d_rvalid_q  <= d_gnt;
      d_err_q     <= d_gnt && d_mis;
      d_rdata_q   <= (d_gnt && !d_we_mis_or_store()) ? bus.mem_q : 32'h0;
    end
  end

  // Loads that are aligned are the only data responses carrying RAM contents.
  function automatic logic d_we_mis_or_store();
    return bus.d_we || d_mis;
  endfunction

  // A response already registered when reset arrives is discarded, not delivered.
  assign bus.if_rvalid = if_rvalid_q && !reset;
  assign bus.if_err    = if_err_q && !reset;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rvalid  = d_rvalid_q && !reset;
  assign bus.d_err     = d_err_q && !reset;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a behavioural RAM.
// Build with MEM_ARB_RR_EN defined to exercise round-robin arbitration.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  logic clock;
  logic reset;
  int   checks;
  int   failures;

  logic [31:0] ram [0:16383];

  mem_port_arbiter_if #(.ADDR_W(16)) bus ();

  mem_port_arbiter #(.ADDR_W(16), .STARVE_LIMIT(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // RAM: combinational read, posedge write
  assign bus.mem_q = ram[bus.mem_addr[15:2]];
  always @(posedge clock) if (bus.mem_we) ram[bus.mem_addr[15:2]] <= bus.mem_d;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.if_req  = 1'b0;
    bus.if_addr = '0;
    bus.d_req   = 1'b0;
    bus.d_we    = 1'b0;
    bus.d_addr  = '0;
    bus.d_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if ({bus.if_gnt, bus.d_gnt, bus.mem_we, bus.if_rvalid, bus.d_rvalid} !== 5'b0) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got gnt/we/rvalid=%b exp=00000", i,
                 {bus.if_gnt, bus.d_gnt, bus.mem_we, bus.if_rvalid, bus.d_rvalid});
      end
      next_cycle();
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.if_gnt !== 1'b0 || bus.mem_addr !== 16'h0020) begin
      failures++;
      $display("FAIL reset_release got d_gnt=%b if_gnt=%b addr=%h exp 1 0 0020",
               bus.d_gnt, bus.if_gnt, bus.mem_addr);
    end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hA000_0008 || bus.d_err !== 1'b0) begin
      failures++;
      $display("FAIL first_load got rvalid=%b rdata=%h err=%b exp 1 a0000008 0",
               bus.d_rvalid, bus.d_rdata, bus.d_err);
    end
    checks++;
    if (bus.mem_addr !== 16'h0 || bus.mem_we !== 1'b0 || bus.mem_d !== 32'h0) begin
      failures++;
      $display("FAIL idle_mem got addr=%h we=%b d=%h exp 0 0 0", bus.mem_addr, bus.mem_we, bus.mem_d);
    end
    next_cycle();
  endtask

  task automatic test_store_load();
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 32'hDEAD_BEEF;
    @(negedge clock);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b1 || bus.mem_addr !== 16'h0010 ||
        bus.mem_d !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL store_issue got gnt=%b we=%b addr=%h d=%h exp 1 1 0010 deadbeef",
               bus.d_gnt, bus.mem_we, bus.mem_addr, bus.mem_d);
    end
    next_cycle();
    bus.d_we = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'h0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL store_ack got gnt=%b rvalid=%b rdata=%h we=%b exp 1 1 0 0",
               bus.d_gnt, bus.d_rvalid, bus.d_rdata, bus.mem_we);
    end
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL load_back got rvalid=%b rdata=%h exp 1 deadbeef", bus.d_rvalid, bus.d_rdata);
    end
    next_cycle();
    @(negedge clock);
    checks++;
    if (bus.d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rvalid_pulse got=%b exp=0", bus.d_rvalid);
    end
    next_cycle();
  endtask

`ifndef MEM_ARB_RR_EN
  task automatic test_starvation();
    logic prev_f, prev_d, exp_f;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    prev_f = 1'b0; prev_d = 1'b0;
    for (int i = 0; i < 10; i++) begin
      exp_f = (i % 5 == 4);
      @(negedge clock);
      checks++;
      if (bus.if_gnt !== exp_f || bus.d_gnt !== !exp_f || bus.if_rvalid !== prev_f ||
          bus.d_rvalid !== prev_d) begin
        failures++;
        $display("FAIL starve cyc=%0d got if_gnt=%b d_gnt=%b if_rv=%b d_rv=%b exp %b %b %b %b",
                 i, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid, exp_f, !exp_f, prev_f, prev_d);
      end
      prev_f = exp_f; prev_d = !exp_f;
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0010 || bus.d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL starve_fetch_data got if_rv=%b rdata=%h d_rv=%b exp 1 a0000010 0",
               bus.if_rvalid, bus.if_rdata, bus.d_rvalid);
    end
    next_cycle();
  endtask
`else
  task automatic test_round_robin();
    logic exp_f;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    bus.d_req  = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0020;
    for (int i = 0; i < 8; i++) begin
      exp_f = (i % 2 == 1);
      @(negedge clock);
      checks++;
      if (bus.if_gnt !== exp_f || bus.d_gnt !== !exp_f) begin
        failures++;
        $display("FAIL rr cyc=%0d got if_gnt=%b d_gnt=%b exp %b %b", i, bus.if_gnt, bus.d_gnt, exp_f, !exp_f);
      end
      next_cycle();
    end
    idle_inputs();
    @(negedge clock);
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'hA000_0010) begin
      failures++;
      $display("FAIL rr_fetch_data got rv=%b rdata=%h exp 1 a0000010", bus.if_rvalid, bus.if_rdata);
    end
    next_cycle();
  endtask
`endif

  task automatic test_misaligned();
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'h0013;
    @(negedge clock);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mis_load_gnt got gnt=%b we=%b exp 1 0", bus.d_gnt, bus.mem_we);
    end
    next_cycle();
    bus.d_we = 1'b1; bus.d_wdata = 32'h1234_5678;
    @(negedge clock);
    checks++;
    if (bus.d_gnt !== 1'b1 || bus.mem_we !== 1'b0 || bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 ||
        bus.d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mis_load_resp got gnt=%b we=%b rv=%b err=%b rdata=%h exp 1 0 1 1 0",
               bus.d_gnt, bus.mem_we, bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    next_cycle();
    bus.d_we = 1'b0; bus.d_addr = 16'h0010;
    @(negedge clock);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1) begin
      failures++;
      $display("FAIL mis_store_resp got rv=%b err=%b exp 1 1", bus.d_rvalid, bus.d_err);
    end
    next_cycle();
    idle_inputs();
    @(negedge clock);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mis_ram_intact got rv=%b err=%b rdata=%h exp 1 0 deadbeef",
               bus.d_rvalid, bus.d_err, bus.d_rdata);
    end
    next_cycle();
    bus.if_req = 1'b1; bus.if_addr = 16'h0042;
    next_cycle();
    bus.if_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b1 || bus.if_rdata !== 32'h0) begin
      failures++;
      $display("FAIL mis_fetch got rv=%b err=%b rdata=%h exp 1 1 0", bus.if_rvalid, bus.if_err, bus.if_rdata);
    end
    next_cycle();
  endtask

  task automatic test_reset_midflight();
    bus.if_req = 1'b1; bus.if_addr = 16'h0040;
    @(negedge clock);
    checks++;
    if (bus.if_gnt !== 1'b1) begin
      failures++;
      $display("FAIL mid_gnt got=%b exp=1", bus.if_gnt);
    end
    next_cycle();
    reset = 1'b1;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'h0010; bus.d_wdata = 32'hBAD0_BAD0;
    @(negedge clock);
    checks++;
    if (bus.if_rvalid !== 1'b0 || bus.if_gnt !== 1'b0 || bus.d_gnt !== 1'b0 || bus.mem_we !== 1'b0) begin
      failures++;
      $display("FAIL mid_discard got if_rv=%b if_gnt=%b d_gnt=%b we=%b exp 0 0 0 0",
               bus.if_rvalid, bus.if_gnt, bus.d_gnt, bus.mem_we);
    end
    next_cycle();
    reset = 1'b0;
    bus.d_req = 1'b0; bus.d_we = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.if_gnt !== 1'b1 || bus.if_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL mid_regrant got gnt=%b rv=%b exp 1 0", bus.if_gnt, bus.if_rvalid);
    end
    next_cycle();
    idle_inputs();
    bus.d_req = 1'b1; bus.d_addr = 16'h0010;
    @(negedge clock);
    checks++;
    if (bus.if_rvalid !== 1'b1 || bus.if_err !== 1'b0 || bus.if_rdata !== 32'hA000_0010) begin
      failures++;
      $display("FAIL mid_clean got rv=%b err=%b rdata=%h exp 1 0 a0000010",
               bus.if_rvalid, bus.if_err, bus.if_rdata);
    end
    next_cycle();
    bus.d_req = 1'b0;
    @(negedge clock);
    checks++;
    if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL mid_no_write got rv=%b rdata=%h exp 1 deadbeef", bus.d_rvalid, bus.d_rdata);
    end
    next_cycle();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 16384; i++) ram[i] = 32'hA000_0000 | 32'(i);
    reset = 1'b1;
    idle_inputs();
    #1;
    test_reset();
    test_store_load();
`ifndef MEM_ARB_RR_EN
    test_starvation();
`else
    test_round_robin();
`endif
    test_misaligned();
    test_reset_midflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
